mem_sram_bridge: RTL and testbench
==================================

# mem_sram_bridge

Data-memory responder for the MEM stage. Takes the load/store request that the EXE/MEM register presents (`MEM_ALUOut`, `MEM_OutB`, `MEM_LoadType`, `MEM_StoreType`) and runs it on an SRAM-like request/`addr_ok`/`data_ok` bus. It returns the raw 32-bit read word as `MEM_DMOut`, which feeds the MEM/WB register; load extension happens later in WB. It also stalls the pipeline until the transaction completes.

## Interface
Parameters:
- `ADDR_W`, 32, data-bus address width.

Ports:
- `clk`  in  1  core clock.
- `rst`  in  1  asynchronous, active-low reset.
- `MEM_ALUOut`  in  32  effective address.
- `MEM_OutB`  in  32  store data, already bypassed.
- `MEM_LoadType`  in  LoadType  `{sign,size,ReadMem}`.
- `MEM_StoreType`  in  StoreType  `{size,DMWr}`.
- `MEM_Kill`  in  1  MEM-stage exception present; suppresses issue.
- `MEM_Hold`  in  1  pipeline frozen by another source this cycle.
- `MEM_DMOut`  out  32  raw read word.
- `MEM_Stall`  out  1  freeze PC/IF/ID/EXE/MEM registers.
- `data_sram_req`  out  1  request valid.
- `data_sram_wr`  out  1  1 = store.
- `data_sram_size`  out  2  00 byte, 01 half, 10 word.
- `data_sram_addr`  out  ADDR_W  address.
- `data_sram_wstrb`  out  4  byte enables.
- `data_sram_wdata`  out  32  replicated store data.
- `data_sram_addr_ok`  in  1  request accepted.
- `data_sram_data_ok`  in  1  read data valid / write done.
- `data_sram_rdata`  in  32  read data.

## Operation
- `acc = (MEM_LoadType.ReadMem | MEM_StoreType.DMWr) & ~MEM_Kill`.
- `MEM_Kill` is sampled only in IDLE. Once a request is on the bus it is never withdrawn.
- FSM states are IDLE, ADDR, DATA, DONE.
  - **IDLE**
    - If `acc`, drive `req=1` with fields taken directly from the inputs and latch the fields.
    - `addr_ok` in the same cycle → DATA; otherwise → ADDR.
  - **ADDR**
    - Hold `req=1` with the latched fields.
    - `addr_ok` → DATA.
  - **DATA**
    - `req=0`; wait for `data_ok`.
    - On `data_ok` with `MEM_Hold=0` → IDLE. `MEM_DMOut = data_sram_rdata` in that cycle (bypass).
    - On `data_ok` with `MEM_Hold=1` → DONE, latching rdata into `rdata_q`.
  - **DONE**
    - `req=0`, `MEM_DMOut = rdata_q`, `MEM_Stall=0`.
    - `MEM_Hold=0` → IDLE.
    - DONE blocks re-issue of the same instruction.
- `MEM_Stall = (IDLE & acc) | ADDR | (DATA & ~data_ok)`.
- Outside the DATA bypass cycle, `MEM_DMOut = rdata_q`.
- Store shaping, with `a = addr[1:0]`:
  - byte: `wstrb = 4'b0001 << a`, `wdata = {4{OutB[7:0]}}`.
  - half: `wstrb = a[1] ? 4'b1100 : 4'b0011`, `wdata = {2{OutB[15:0]}}`.
  - word: `wstrb = 4'b1111`, `wdata = OutB`.
  - Size 11 is treated as word.
- Loads: `wr=0`, `wstrb=0`, `size = LoadType.size`.
- If both ReadMem and DMWr are set, the store wins.
- Misaligned addresses are excluded upstream through `MEM_Kill`. The address passes through untranslated.

## Timing
- Reset (async, `rst=0`):
  - state = IDLE.
  - `rdata_q`, latched fields = 0.
  - `data_sram_req`, `data_sram_wr` = 0.
  - `MEM_DMOut` = 0; `MEM_Stall` = 0 with no access pending.
  - Reset mid-transaction abandons it. Any late `data_ok` after reset is ignored because the state is IDLE.
- Minimum latency with `addr_ok` in the issue cycle and `data_ok` on the next cycle:
  - 2 cycles, 1 stall cycle.
  - The pipeline advances on the edge after the `data_ok` cycle.
- `data_ok` never arrives in the `addr_ok` cycle (bus rule). `data_ok` seen in IDLE/ADDR/DONE is ignored.
- Exactly one outstanding transaction at a time.
- `MEM_Hold` never affects the bus. It only selects DATA→DONE versus DATA→IDLE.

## Structure
- Shared package:
  - `MemAccState` enum (IDLE/ADDR/DATA/DONE).
  - Size encodings `SIZE_BYTE`, `SIZE_HALF`, `SIZE_WORD`.
  - Reuse `LoadType`/`StoreType` from the CPU defines.
- Sub-module `store_align`: combinational size/addr/data → wstrb/wdata.
- FSM, field latch and `rdata_q` live in the top.

## Test plan
- Load word, addr `0x8000_0010`, `addr_ok` same cycle, `data_ok` +1 with rdata `0xDEAD_BEEF` → `MEM_Stall` high 1 cycle; `MEM_DMOut=0xDEADBEEF` in the `data_ok` cycle; state returns to IDLE.
- Store byte `0x0000_00A5` at addr `…_0003` → `wr=1`, `size=00`, `wstrb=4'b1000`, `wdata=0xA5A5A5A5`. Half store at `…_0002` → `wstrb=4'b1100`.
- `addr_ok` delayed 3 cycles → `req` and fields held constant for 4 cycles; stall held until `data_ok`.
- `data_ok` with `MEM_Hold=1` for 2 cycles → DONE; `MEM_DMOut` holds rdata; no second `req`; IDLE after `Hold` drops.
- `MEM_Kill=1` with ReadMem → no `req`, `MEM_Stall=0`. Kill raised while in ADDR → `req` still held until `addr_ok`.
- `rst` pulled low in DATA → immediately `req=0`, `MEM_Stall=0`, `MEM_DMOut=0`. A later stray `data_ok` is ignored.

Source files
------------

// File: rtl/mem_sram_bridge_pkg.sv
// Shared types and encodings for the MEM-stage SRAM bridge.
package mem_sram_bridge_pkg;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned STRB_W = 4;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2,
    DONE = 2'd3
  } MemAccState;

  // Pipeline load/store control as carried by the EXE/MEM register.
  typedef struct packed {
    logic       sign;
    logic [1:0] size;
    logic       ReadMem;
  } LoadType;

  typedef struct packed {
    logic [1:0] size;
    logic       DMWr;
  } StoreType;

  // Request fields driven on the bus (address is kept separately, it is ADDR_W wide).
  typedef struct packed {
    logic              wr;
    logic [1:0]        size;
    logic [STRB_W-1:0] wstrb;
    logic [DATA_W-1:0] wdata;
  } sram_fields_t;

endpackage

// File: rtl/mem_sram_bridge_store_align.sv
// Byte-lane shaping of store data: size/address offset -> byte enables and replicated data.
module mem_sram_bridge_store_align
  import mem_sram_bridge_pkg::*;
(
  input  logic [1:0]        size_i,
  input  logic [1:0]        addr_lo_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [STRB_W-1:0] wstrb_o,
  output logic [DATA_W-1:0] wdata_o
);

  // Lane select and replication; size 11 falls through to word.
  always_comb begin
    wstrb_o = '0;
    wdata_o = '0;
    case (size_i)
      SIZE_BYTE: begin
        wstrb_o = STRB_W'(4'b0001 << addr_lo_i);
        wdata_o = {4{data_i[7:0]}};
      end
      SIZE_HALF: begin
        wstrb_o = addr_lo_i[1] ? 4'b1100 : 4'b0011;
        wdata_o = {2{data_i[15:0]}};
      end
      default: begin
        wstrb_o = 4'b1111;
        wdata_o = data_i;
      end
    endcase
  end

endmodule

// File: rtl/mem_sram_bridge.sv
// MEM-stage data-memory responder: runs one load/store on an SRAM-like
// req/addr_ok/data_ok bus and stalls the pipeline until it completes.
module mem_sram_bridge
  import mem_sram_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       MEM_ALUOut,
  input  logic [31:0]       MEM_OutB,
  input  LoadType           MEM_LoadType,
  input  StoreType          MEM_StoreType,
  input  logic              MEM_Kill,
  input  logic              MEM_Hold,
  output logic [31:0]       MEM_DMOut,
  output logic              MEM_Stall,
  output logic              data_sram_req,
  output logic              data_sram_wr,
  output logic [1:0]        data_sram_size,
  output logic [ADDR_W-1:0] data_sram_addr,
  output logic [3:0]        data_sram_wstrb,
  output logic [31:0]       data_sram_wdata,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata
);

  MemAccState        state_q, state_d;
  sram_fields_t      fld_q, fld_d, issue_c, bus_c;
  logic [ADDR_W-1:0] addr_q, addr_d, bus_addr_c;
  logic [31:0]       rdata_q, rdata_d;
  logic              acc_c, req_c, stall_c;
  logic [31:0]       dmout_c;
  logic [1:0]        st_size_c;
  logic [3:0]        align_wstrb;
  logic [31:0]       align_wdata;
  logic              unused_sign;

  // Sign extension is applied in WB; the bridge returns the raw word.
  assign unused_sign = MEM_LoadType.sign;

  assign acc_c     = (MEM_LoadType.ReadMem | MEM_StoreType.DMWr) & ~MEM_Kill;
  assign st_size_c = (MEM_StoreType.size == 2'b11) ? SIZE_WORD : MEM_StoreType.size;

  mem_sram_bridge_store_align store_align (
    .size_i    (st_size_c),
    .addr_lo_i (MEM_ALUOut[1:0]),
    .data_i    (MEM_OutB),
    .wstrb_o   (align_wstrb),
    .wdata_o   (align_wdata)
  );

  // Request fields built from the current inputs; a store takes priority over a load.
  always_comb begin
    issue_c = '0;
    if (MEM_StoreType.DMWr) begin
      issue_c.wr    = 1'b1;
      issue_c.size  = st_size_c;
      issue_c.wstrb = align_wstrb;
      issue_c.wdata = align_wdata;
    end else begin
      issue_c.size  = MEM_LoadType.size;
    end
  end

  // Next state, field latch, read-data capture and bus/pipeline outputs.
  always_comb begin
    state_d    = state_q;
    fld_d      = fld_q;
    addr_d     = addr_q;
    rdata_d    = rdata_q;
    req_c      = 1'b0;
    stall_c    = 1'b0;
    dmout_c    = rdata_q;
    bus_c      = fld_q;
    bus_addr_c = addr_q;
    case (state_q)
      IDLE: begin
        if (acc_c) begin
          req_c      = 1'b1;
          stall_c    = 1'b1;
          bus_c      = issue_c;
          bus_addr_c = ADDR_W'(MEM_ALUOut);
          fld_d      = issue_c;
          addr_d     = ADDR_W'(MEM_ALUOut);
          state_d    = data_sram_addr_ok ? DATA : ADDR;
        end
      end
      ADDR: begin
        req_c   = 1'b1;
        stall_c = 1'b1;
        if (data_sram_addr_ok) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (data_sram_data_ok) begin
          dmout_c = data_sram_rdata;
          if (MEM_Hold) begin
            rdata_d = data_sram_rdata;
            state_d = DONE;
          end else begin
            state_d = IDLE;
          end
        end else begin
          stall_c = 1'b1;
        end
      end
      DONE: begin
        if (!MEM_Hold) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, latched request fields and captured read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      fld_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      fld_q   <= fld_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign data_sram_req   = req_c;
  assign data_sram_wr    = bus_c.wr;
  assign data_sram_size  = bus_c.size;
  assign data_sram_addr  = bus_addr_c;
  assign data_sram_wstrb = bus_c.wstrb;
  assign data_sram_wdata = bus_c.wdata;
  assign MEM_DMOut       = dmout_c;
  assign MEM_Stall       = stall_c;

endmodule

// File: tb/tb_mem_sram_bridge.sv
// Self-checking bench for mem_sram_bridge: directed cases then randomized transactions.
module tb_mem_sram_bridge;
  import mem_sram_bridge_pkg::*;

  localparam int unsigned AW = 32;

  logic          clk;
  logic          rst_n;
  logic [31:0]   alu;
  logic [31:0]   outb;
  LoadType       ld;
  StoreType      st;
  logic          kill;
  logic          hold;
  logic [31:0]   dmout;
  logic          stall;
  logic          req;
  logic          wr;
  logic [1:0]    size;
  logic [AW-1:0] addr;
  logic [3:0]    wstrb;
  logic [31:0]   wdata;
  logic          addr_ok;
  logic          data_ok;
  logic [31:0]   rdata;

  int          total = 0;
  int          bad = 0;
  int          txn_id = 0;
  logic [31:0] mdl_rdata;   // value the bridge shows while not in the bypass cycle

  mem_sram_bridge #(.ADDR_W(AW)) dut (
    .clk               (clk),
    .rst               (rst_n),
    .MEM_ALUOut        (alu),
    .MEM_OutB          (outb),
    .MEM_LoadType      (ld),
    .MEM_StoreType     (st),
    .MEM_Kill          (kill),
    .MEM_Hold          (hold),
    .MEM_DMOut         (dmout),
    .MEM_Stall         (stall),
    .data_sram_req     (req),
    .data_sram_wr      (wr),
    .data_sram_size    (size),
    .data_sram_addr    (addr),
    .data_sram_wstrb   (wstrb),
    .data_sram_wdata   (wdata),
    .data_sram_addr_ok (addr_ok),
    .data_sram_data_ok (data_ok),
    .data_sram_rdata   (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s txn=%0d observed=%h expected=%h", tag, txn_id, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    ld      = '0;
    st      = '0;
    alu     = $urandom;
    outb    = $urandom;
    kill    = 1'b0;
    hold    = 1'b0;
    addr_ok = 1'b0;
    data_ok = 1'b0;
    rdata   = $urandom;
  endtask

  // Expected bus fields, derived lane by lane from the access description.
  task automatic model_fields(input LoadType l, input StoreType s, input logic [31:0] a,
                              input logic [31:0] d, output logic e_wr, output logic [1:0] e_size,
                              output logic [3:0] e_strb, output logic [31:0] e_data);
    e_data = 32'h0;
    e_strb = 4'h0;
    if (s.DMWr) begin
      e_wr   = 1'b1;
      e_size = (s.size == 2'd3) ? 2'd2 : s.size;
      if (e_size == 2'd0) begin
        for (int i = 0; i < 4; i++) e_strb[i] = (i == int'(a[1:0]));
        e_data = 32'h0101_0101 * d[7:0];
      end else if (e_size == 2'd1) begin
        for (int i = 0; i < 4; i++) e_strb[i] = ((i / 2) == int'(a[1]));
        e_data = 32'h0001_0001 * d[15:0];
      end else begin
        e_strb = 4'hF;
        e_data = d;
      end
    end else begin
      e_wr   = 1'b0;
      e_size = l.size;
    end
  endtask

  task automatic check_fields(input string ph, input logic e_wr, input logic [1:0] e_size,
                              input logic [3:0] e_strb, input logic [31:0] e_data,
                              input logic [31:0] e_addr);
    chk({ph, " req"}, 32'(req), 32'd1);
    chk({ph, " wr"}, 32'(wr), 32'(e_wr));
    chk({ph, " size"}, 32'(size), 32'(e_size));
    chk({ph, " addr"}, addr, e_addr);
    chk({ph, " wstrb"}, 32'(wstrb), 32'(e_strb));
    if (e_wr) chk({ph, " wdata"}, wdata, e_data);
    chk({ph, " stall"}, 32'(stall), 32'd1);
  endtask

  // One complete access: issue, alat cycles of addr_ok delay, data_ok dlat cycles
  // after acceptance, Hold kept for holdc cycles starting in the data_ok cycle.
  task automatic run_txn(input LoadType l, input StoreType s, input logic [31:0] a,
                         input logic [31:0] d, input int alat, input int dlat,
                         input int holdc, input bit kill_addr, input logic [31:0] rd);
    logic        e_wr;
    logic [1:0]  e_size;
    logic [3:0]  e_strb;
    logic [31:0] e_data;
    txn_id++;
    model_fields(l, s, a, d, e_wr, e_size, e_strb, e_data);
    ld = l; st = s; alu = a; outb = d; kill = 1'b0; hold = 1'b0;
    addr_ok = (alat == 0); data_ok = 1'b0; rdata = $urandom;
    #1;
    check_fields("issue", e_wr, e_size, e_strb, e_data, a);
    chk("issue dmout", dmout, mdl_rdata);
    step();
    for (int k = 1; k <= alat; k++) begin
      kill    = kill_addr;
      alu     = $urandom;
      outb    = $urandom;
      addr_ok = (k == alat);
      data_ok = (k == alat) ? 1'b0 : 1'($urandom % 2);
      rdata   = $urandom;
      #1;
      check_fields("wait_addr", e_wr, e_size, e_strb, e_data, a);
      step();
    end
    addr_ok = 1'b0;
    alu = a; outb = d;
    for (int j = 1; j < dlat; j++) begin
      data_ok = 1'b0;
      rdata   = $urandom;
      #1;
      chk("wait_data req", 32'(req), 32'd0);
      chk("wait_data stall", 32'(stall), 32'd1);
      chk("wait_data dmout", dmout, mdl_rdata);
      step();
    end
    data_ok = 1'b1;
    rdata   = rd;
    hold    = (holdc > 0);
    #1;
    chk("data_ok req", 32'(req), 32'd0);
    chk("data_ok stall", 32'(stall), 32'd0);
    chk("data_ok dmout", dmout, rd);
    step();
    if (holdc > 0) mdl_rdata = rd;
    for (int h = 1; h <= holdc; h++) begin
      data_ok = 1'($urandom % 2);
      rdata   = $urandom;
      hold    = (h < holdc);
      #1;
      chk("held req", 32'(req), 32'd0);
      chk("held stall", 32'(stall), 32'd0);
      chk("held dmout", dmout, rd);
      step();
    end
    drive_idle();
    #1;
    chk("after req", 32'(req), 32'd0);
    chk("after stall", 32'(stall), 32'd0);
    chk("after dmout", dmout, mdl_rdata);
    step();
  endtask

  initial begin
    LoadType     l;
    StoreType    s;
    logic [31:0] a;
    int          kind;

    mdl_rdata = 32'h0;
    rst_n = 1'b0;
    drive_idle();
    #2;
    chk("reset req", 32'(req), 32'd0);
    chk("reset wr", 32'(wr), 32'd0);
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset dmout", dmout, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    // Minimum-latency load word.
    run_txn('{sign: 1'b0, size: 2'd2, ReadMem: 1'b1}, '0, 32'h8000_0010, 32'h0,
            0, 1, 0, 1'b0, 32'hDEAD_BEEF);
    // Byte store at offset 3, half store at offset 2, size-11 store.
    run_txn('0, '{size: 2'd0, DMWr: 1'b1}, 32'h0000_0003, 32'h0000_00A5, 0, 1, 0, 1'b0, 32'h0);
    run_txn('0, '{size: 2'd1, DMWr: 1'b1}, 32'h0000_0002, 32'h1234_BEEF, 0, 1, 0, 1'b0, 32'h0);
    run_txn('0, '{size: 2'd3, DMWr: 1'b1}, 32'h0000_0001, 32'hCAFE_F00D, 1, 1, 0, 1'b0, 32'h0);
    // Delayed acceptance with Kill raised while waiting.
    run_txn('{sign: 1'b1, size: 2'd1, ReadMem: 1'b1}, '0, 32'h1000_0006, 32'h0,
            3, 2, 0, 1'b1, 32'h5555_AAAA);
    // Completion while the pipeline is held elsewhere.
    run_txn('{sign: 1'b0, size: 2'd2, ReadMem: 1'b1}, '0, 32'h2000_0000, 32'h0,
            0, 1, 2, 1'b0, 32'h1357_9BDF);

    // Killed access never reaches the bus.
    ld = '{sign: 1'b0, size: 2'd2, ReadMem: 1'b1};
    kill = 1'b1;
    alu = 32'h3000_0000;
    for (int i = 0; i < 2; i++) begin
      addr_ok = 1'b1;
      #1;
      chk("kill req", 32'(req), 32'd0);
      chk("kill stall", 32'(stall), 32'd0);
      step();
    end
    drive_idle();
    step();

    // Reset while waiting for data; a later stray data_ok is ignored.
    ld = '{sign: 1'b0, size: 2'd2, ReadMem: 1'b1};
    alu = 32'h4000_0000;
    addr_ok = 1'b1;
    #1;
    step();
    drive_idle();
    rst_n = 1'b0;
    mdl_rdata = 32'h0;
    #1;
    chk("rst_data req", 32'(req), 32'd0);
    chk("rst_data wr", 32'(wr), 32'd0);
    chk("rst_data stall", 32'(stall), 32'd0);
    chk("rst_data dmout", dmout, 32'h0);
    step();
    rst_n = 1'b1;
    step();
    data_ok = 1'b1;
    rdata = 32'hFFFF_0000;
    #1;
    chk("stray req", 32'(req), 32'd0);
    chk("stray stall", 32'(stall), 32'd0);
    chk("stray dmout", dmout, 32'h0);
    step();
    drive_idle();
    step();

    // Randomized accesses.
    for (int n = 0; n < 60; n++) begin
      kind = int'($urandom % 3);
      l = '0;
      s = '0;
      if (kind != 1) l = '{sign: 1'($urandom % 2), size: 2'($urandom % 3), ReadMem: 1'b1};
      if (kind != 0) s = '{size: 2'($urandom % 4), DMWr: 1'b1};
      a = $urandom;
      run_txn(l, s, a, $urandom, int'($urandom % 4), 1 + int'($urandom % 3),
              int'($urandom % 3), 1'($urandom % 2), $urandom);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
